// File: rtl/ram_4096.sv
// rtl/ram_4096.sv - 4096 x 64 simple dual-port RAM with per-word valid tracking
//
// Purpose:
//   Synchronous simple dual-port RAM, one write port and one read port on a
//   single clock. Each word carries a valid flag so that a location never
//   written since the last reset reads back as zero. Reads are registered
//   with one cycle of latency and are read-first on a same-address collision.
//
// Ports:
//   clk         in   1           system clock, rising edge
//   rst         in   1           synchronous active-high reset
//   data_in     in   DATA_WIDTH  write data
//   wr_address  in   ADDR_WIDTH  write address
//   write       in   1           write enable
//   rd_address  in   ADDR_WIDTH  read address
//   read        in   1           read enable
//   data_out    out  DATA_WIDTH  registered read data, holds when read=0

module ram_4096 #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] wr_address,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [DEPTH-1:0]      valid_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] data_out_d;

  // The array itself is never reset; the valid flags alone decide whether a
  // stored word is visible, which keeps the array free of reset logic.
  always_ff @(posedge clk) begin
    if (!rst && write) begin
      mem_q[wr_address] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (write) begin
      valid_q[wr_address] <= 1'b1;
    end
  end

  // Reads sample the pre-edge array and flags, so a write to the same
  // address in the same cycle is not seen until the next read (read-first).
  always_comb begin
    data_out_d = data_out_q;
    if (read) begin
      data_out_d = valid_q[rd_address] ? mem_q[rd_address] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_ram_4096.sv
// tb/tb_ram_4096.sv - directed self-checking bench for ram_4096

module tb_ram_4096;

  logic        clk;
  logic        rst;
  logic [63:0] data_in;
  logic [11:0] wr_address;
  logic        write;
  logic [11:0] rd_address;
  logic        read;
  logic [63:0] data_out;

  int vec_count;
  int miscompares;

  ram_4096 dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .wr_address (wr_address),
    .write      (write),
    .rd_address (rd_address),
    .read       (read),
    .data_out   (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle a little past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [11:0] sweep_addr [5];

  initial begin
    vec_count   = 0;
    miscompares = 0;
    sweep_addr[0] = 12'h000;
    sweep_addr[1] = 12'h001;
    sweep_addr[2] = 12'h7FF;
    sweep_addr[3] = 12'h800;
    sweep_addr[4] = 12'hFFF;

    rst = 1'b1; write = 1'b0; read = 1'b0;
    data_in = '0; wr_address = '0; rd_address = '0;

    // Reset for two cycles, then read both address extremes.
    tick();
    tick();
    check_vec("reset_data_out", data_out, 64'h0);
    rst = 1'b0;
    read = 1'b1; rd_address = 12'h000;
    tick();
    check_vec("reset_rd_000", data_out, 64'h0);
    rd_address = 12'hFFF;
    tick();
    check_vec("reset_rd_fff", data_out, 64'h0);
    read = 1'b0;

    // Basic write then read, followed by a five-cycle hold.
    write = 1'b1; wr_address = 12'h123; data_in = 64'hDEADBEEF_CAFEF00D;
    tick();
    write = 1'b0;
    read = 1'b1; rd_address = 12'h123;
    tick();
    check_vec("basic_rd_123", data_out, 64'hDEADBEEF_CAFEF00D);
    read = 1'b0; rd_address = 12'h000;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_vec("basic_hold", data_out, 64'hDEADBEEF_CAFEF00D);
    end

    // Boundary sweep: each word stores its own address.
    write = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wr_address = sweep_addr[k];
      data_in    = {52'h0, sweep_addr[k]};
      tick();
    end
    write = 1'b0;
    read = 1'b1;
    for (int k = 0; k < 5; k++) begin
      rd_address = sweep_addr[k];
      tick();
      check_vec($sformatf("sweep_rd_%03h", sweep_addr[k]), data_out, {52'h0, sweep_addr[k]});
    end
    rd_address = 12'h555;
    tick();
    check_vec("sweep_unwritten_555", data_out, 64'h0);
    read = 1'b0;

    // Same-address collision on a previously written word.
    write = 1'b1; wr_address = 12'h010; data_in = 64'hAAAAAAAA_AAAAAAAA;
    tick();
    data_in = 64'h55555555_55555555;
    read = 1'b1; rd_address = 12'h010;
    tick();
    check_vec("collide_old_010", data_out, 64'hAAAAAAAA_AAAAAAAA);
    write = 1'b0;
    tick();
    check_vec("collide_new_010", data_out, 64'h55555555_55555555);

    // Same-address collision on a fresh word returns zero first.
    write = 1'b1; wr_address = 12'h030; data_in = 64'h12345678_9ABCDEF0;
    rd_address = 12'h030;
    tick();
    check_vec("collide_fresh_030", data_out, 64'h0);
    write = 1'b0;
    tick();
    check_vec("collide_after_030", data_out, 64'h12345678_9ABCDEF0);

    // Concurrent ports: write i while reading i-1, every cycle.
    write = 1'b1; read = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      wr_address = 12'(i);
      data_in    = 64'(i * 3);
      rd_address = 12'(i - 1);
      tick();
      check_vec($sformatf("concurrent_rd_%0d", i - 1), data_out, 64'((i - 1) * 3));
    end
    write = 1'b0; read = 1'b0;

    // Reset mid-stream with a coincident write that must be lost.
    write = 1'b1; wr_address = 12'h020; data_in = 64'h11111111_11111111;
    tick();
    rst = 1'b1; wr_address = 12'h021; data_in = 64'h22222222_22222222;
    tick();
    rst = 1'b0; write = 1'b0;
    check_vec("midrst_data_out", data_out, 64'h0);
    read = 1'b1; rd_address = 12'h020;
    tick();
    check_vec("midrst_rd_020", data_out, 64'h0);
    rd_address = 12'h021;
    tick();
    check_vec("midrst_rd_021", data_out, 64'h0);
    rd_address = 12'h123;
    tick();
    check_vec("midrst_rd_123", data_out, 64'h0);
    read = 1'b0;

    // Rewrite after reset becomes visible again.
    write = 1'b1; wr_address = 12'h021; data_in = 64'h0F0F0F0F_0F0F0F0F;
    tick();
    write = 1'b0; read = 1'b1; rd_address = 12'h021;
    tick();
    check_vec("rewrite_rd_021", data_out, 64'h0F0F0F0F_0F0F0F0F);
    read = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
